core_control_sequencer: RTL and testbench

- Multi-cycle control FSM for the RV32I core. Sequences instruction fetch, decode, execute, memory access and writeback around the instruction decoder, register file, ALU and a single shared memory port.
- Owns the PC-update and trap policy. Raises illegal-instruction and bus-timeout traps.
- Sits between the memory interface and the datapath. Consumes InvalidInstructionSignal from the decoder.

---
 rtl/rv_pkg.sv | 40 ++++
 rtl/bus_timeout_timer.sv | 38 +++
 rtl/core_control_sequencer.sv | 168 ++++++++++++++++
 tb/tb_core_control_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I constants: opcodes, PC-select and trap-cause encodings, and
// the control sequencer state encoding.
package rv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] PCSEL_PLUS4 = 2'b00;
    localparam logic [1:0] PCSEL_REL   = 2'b01;
    localparam logic [1:0] PCSEL_JALR  = 2'b10;
    localparam logic [1:0] PCSEL_TRAP  = 2'b11;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_DECODE    = 3'd2;
    localparam logic [2:0] ST_EXECUTE   = 3'd3;
    localparam logic [2:0] ST_MEM       = 3'd4;
    localparam logic [2:0] ST_WRITEBACK = 3'd5;
    localparam logic [2:0] ST_TRAP      = 3'd6;
    localparam logic [2:0] ST_HALT      = 3'd7;

    // Opcodes that finish through a register writeback cycle.
    function automatic logic is_wb_opcode(input logic [6:0] opc);
        return (opc == OPC_OP)  || (opc == OPC_OPIMM) || (opc == OPC_LUI) ||
               (opc == OPC_AUIPC) || (opc == OPC_JAL) || (opc == OPC_JALR);
    endfunction

endpackage

// File: rtl/bus_timeout_timer.sv
// Counts wait cycles of a pending memory access and flags expiry when the
// last allowed wait cycle passes without a handshake.
module bus_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMER_WIDTH    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    logic [TIMER_WIDTH-1:0] count_reg;

    // Wait-cycle counter; a fresh access always starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (count_en) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            assign expire = 1'b0;
        end else begin : g_enabled
            localparam logic [TIMER_WIDTH-1:0] LAST_COUNT = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
            // count_en already excludes a cycle with MemReady, so a handshake
            // on the last cycle wins over expiry.
            assign expire = count_en && (count_reg == LAST_COUNT);
        end
    endgenerate

endmodule

// File: rtl/core_control_sequencer.sv
// Multi-cycle RV32I control FSM: fetch, decode, execute, memory, writeback,
// with illegal-instruction and bus-timeout traps and a sticky halt.
module core_control_sequencer
    import rv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMER_WIDTH    = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] Instruction,
    input  logic        MemReady,
    input  logic        InvalidInstructionSignal,
    input  logic        BranchTaken,
    output logic        MemRequest,
    output logic        MemWrite,
    output logic        MemAddrSelect,
    output logic        InstructionLatchEnable,
    output logic        RegFileWriteEnable,
    output logic        PCWriteEnable,
    output logic [1:0]  PCSelect,
    output logic        TrapSignal,
    output logic [1:0]  TrapCause,
    output logic        Halted
);

    logic [2:0] state_reg, state_next;
    logic [6:0] opcode_reg, opcode_next;
    logic [4:0] rd_reg, rd_next;
    logic [1:0] cause_reg, cause_next;
    logic       in_mem_wait;
    logic       timer_clear;
    logic       timer_count_en;
    logic       timer_expire;

    // Only opcode and rd are needed by the sequencer; the rest of the word
    // belongs to the decoder.
    logic unused_instr_bits;
    assign unused_instr_bits = ^Instruction[31:12];

    assign in_mem_wait    = (state_reg == ST_FETCH) || (state_reg == ST_MEM);
    assign timer_count_en = in_mem_wait && !MemReady;
    assign timer_clear    = ((state_next == ST_FETCH) || (state_next == ST_MEM)) &&
                            (state_next != state_reg);

    bus_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TIMER_WIDTH   (TIMER_WIDTH)
    ) u_timer (
        .clk     (Clock),
        .rst     (Reset),
        .clear   (timer_clear),
        .count_en(timer_count_en),
        .expire  (timer_expire)
    );

    // State and latched instruction fields; reset abandons any access at once.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_reg  <= ST_IDLE;
            opcode_reg <= '0;
            rd_reg     <= '0;
            cause_reg  <= CAUSE_NONE;
        end else begin
            state_reg  <= state_next;
            opcode_reg <= opcode_next;
            rd_reg     <= rd_next;
            cause_reg  <= cause_next;
        end
    end

    // Next-state and control outputs from state, latched opcode and inputs.
    always_comb begin
        state_next             = state_reg;
        opcode_next            = opcode_reg;
        rd_next                = rd_reg;
        cause_next             = cause_reg;
        MemRequest             = 1'b0;
        MemWrite               = 1'b0;
        MemAddrSelect          = 1'b0;
        InstructionLatchEnable = 1'b0;
        RegFileWriteEnable     = 1'b0;
        PCWriteEnable          = 1'b0;
        PCSelect               = PCSEL_PLUS4;
        TrapSignal             = 1'b0;
        TrapCause              = CAUSE_NONE;
        Halted                 = 1'b0;
        case (state_reg)
            ST_IDLE: state_next = ST_FETCH;
            ST_FETCH: begin
                MemRequest = 1'b1;
                if (MemReady) begin
                    InstructionLatchEnable = 1'b1;
                    opcode_next            = Instruction[6:0];
                    rd_next                = Instruction[11:7];
                    state_next             = ST_DECODE;
                end else if (timer_expire) begin
                    cause_next = CAUSE_TIMEOUT;
                    state_next = ST_TRAP;
                end
            end
            ST_DECODE: begin
                if (InvalidInstructionSignal) begin
                    cause_next = CAUSE_ILLEGAL;
                    state_next = ST_TRAP;
                end else if (opcode_reg == OPC_SYSTEM) begin
                    state_next = ST_HALT;
                end else begin
                    state_next = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (opcode_reg == OPC_BRANCH) begin
                    PCWriteEnable = 1'b1;
                    PCSelect      = BranchTaken ? PCSEL_REL : PCSEL_PLUS4;
                    state_next    = ST_FETCH;
                end else if ((opcode_reg == OPC_LOAD) || (opcode_reg == OPC_STORE)) begin
                    state_next = ST_MEM;
                end else if (is_wb_opcode(opcode_reg)) begin
                    state_next = ST_WRITEBACK;
                end else begin
                    // Decoder should have flagged this; trap rather than guess.
                    cause_next = CAUSE_ILLEGAL;
                    state_next = ST_TRAP;
                end
            end
            ST_MEM: begin
                MemRequest    = 1'b1;
                MemAddrSelect = 1'b1;
                MemWrite      = (opcode_reg == OPC_STORE);
                if (MemReady) begin
                    if (opcode_reg == OPC_STORE) begin
                        PCWriteEnable = 1'b1;
                        PCSelect      = PCSEL_PLUS4;
                        state_next    = ST_FETCH;
                    end else begin
                        state_next = ST_WRITEBACK;
                    end
                end else if (timer_expire) begin
                    cause_next = CAUSE_TIMEOUT;
                    state_next = ST_TRAP;
                end
            end
            ST_WRITEBACK: begin
                RegFileWriteEnable = (rd_reg != 5'd0);
                PCWriteEnable      = 1'b1;
                if (opcode_reg == OPC_JAL) begin
                    PCSelect = PCSEL_REL;
                end else if (opcode_reg == OPC_JALR) begin
                    PCSelect = PCSEL_JALR;
                end else begin
                    PCSelect = PCSEL_PLUS4;
                end
                state_next = ST_FETCH;
            end
            ST_TRAP: begin
                TrapSignal    = 1'b1;
                TrapCause     = cause_reg;
                PCWriteEnable = 1'b1;
                PCSelect      = PCSEL_TRAP;
                state_next    = ST_FETCH;
            end
            ST_HALT: Halted = 1'b1;
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_core_control_sequencer.sv
// Directed bench: each stimulus cycle pushes the expected output vector; a
// monitor on the falling edge pops and compares it against the DUT outputs.
module tb_core_control_sequencer;

    // Output vector: {req, wr, asel, ile, rfwe, pcwe, pcsel[1:0], trap, cause[1:0], halt}
    localparam logic [11:0] O_ZERO      = 12'b0000_0000_0000;
    localparam logic [11:0] O_FWAIT     = 12'b1000_0000_0000;
    localparam logic [11:0] O_FHIT      = 12'b1001_0000_0000;
    localparam logic [11:0] O_WB_RD     = 12'b0000_1100_0000;
    localparam logic [11:0] O_WB_NORD   = 12'b0000_0100_0000;
    localparam logic [11:0] O_WB_JAL    = 12'b0000_1101_0000;
    localparam logic [11:0] O_WB_JALR0  = 12'b0000_0110_0000;
    localparam logic [11:0] O_BR_T      = 12'b0000_0101_0000;
    localparam logic [11:0] O_BR_NT     = 12'b0000_0100_0000;
    localparam logic [11:0] O_MEM_LD    = 12'b1010_0000_0000;
    localparam logic [11:0] O_MEM_ST    = 12'b1110_0100_0000;
    localparam logic [11:0] O_TRAP_ILL  = 12'b0000_0111_1010;
    localparam logic [11:0] O_TRAP_TO   = 12'b0000_0111_1100;
    localparam logic [11:0] O_HALT      = 12'b0000_0000_0001;

    localparam logic [31:0] I_ADD   = 32'h002081B3; // add x3,x1,x2
    localparam logic [31:0] I_BEQ   = 32'h00208463; // beq x1,x2,8
    localparam logic [31:0] I_LW    = 32'h0000A183; // lw x3,0(x1)
    localparam logic [31:0] I_SW    = 32'h0020A023; // sw x2,0(x1), rd field 0
    localparam logic [31:0] I_NOP   = 32'h00000013; // addi x0,x0,0
    localparam logic [31:0] I_JAL   = 32'h008000EF; // jal x1,8
    localparam logic [31:0] I_JALR  = 32'h00008067; // jalr x0,0(x1)
    localparam logic [31:0] I_BAD   = 32'hFFFFFFFF;
    localparam logic [31:0] I_ECALL = 32'h00000073;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] Instruction;
    logic        MemReady;
    logic        InvalidInstructionSignal;
    logic        BranchTaken;
    logic        MemRequest, MemWrite, MemAddrSelect, InstructionLatchEnable;
    logic        RegFileWriteEnable, PCWriteEnable, TrapSignal, Halted;
    logic [1:0]  PCSelect, TrapCause;

    logic [11:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;

    core_control_sequencer #(.TIMEOUT_CYCLES(4), .TIMER_WIDTH(8)) dut (
        .Clock                   (Clock),
        .Reset                   (Reset),
        .Instruction             (Instruction),
        .MemReady                (MemReady),
        .InvalidInstructionSignal(InvalidInstructionSignal),
        .BranchTaken             (BranchTaken),
        .MemRequest              (MemRequest),
        .MemWrite                (MemWrite),
        .MemAddrSelect           (MemAddrSelect),
        .InstructionLatchEnable  (InstructionLatchEnable),
        .RegFileWriteEnable      (RegFileWriteEnable),
        .PCWriteEnable           (PCWriteEnable),
        .PCSelect                (PCSelect),
        .TrapSignal              (TrapSignal),
        .TrapCause               (TrapCause),
        .Halted                  (Halted)
    );

    always #5 Clock = ~Clock;

    logic [11:0] outs;
    assign outs = {MemRequest, MemWrite, MemAddrSelect, InstructionLatchEnable,
                   RegFileWriteEnable, PCWriteEnable, PCSelect, TrapSignal,
                   TrapCause, Halted};

    // Monitor: compare one expected vector per cycle on the falling edge.
    always @(negedge Clock) begin
        if (exp_q.size() > 0) begin
            logic [11:0] e;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (outs !== e) begin
                errors++;
                $display("FAIL %s: got %b expected %b", nm, outs, e);
            end else begin
                $display("check %-20s outputs=%b ok", nm, outs);
            end
        end
    end

    // Drive one cycle of inputs and queue the expected outputs for it.
    task automatic cyc(input logic rst, input logic [31:0] ins, input logic rdy,
                       input logic inv, input logic bt, input logic [11:0] e,
                       input string nm);
        Reset                    = rst;
        Instruction              = ins;
        MemReady                 = rdy;
        InvalidInstructionSignal = inv;
        BranchTaken              = bt;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        Instruction = '0;
        MemReady = 1'b0;
        InvalidInstructionSignal = 1'b0;
        BranchTaken = 1'b0;
        @(posedge Clock);
        #1;

        cyc(1, 32'h0, 0, 0, 0, O_ZERO, "reset");
        cyc(1, I_ADD, 1, 1, 1, O_ZERO, "reset_inputs_active");
        cyc(0, I_ADD, 0, 0, 0, O_ZERO, "idle");

        // ADD, zero-wait; MemReady outside FETCH/MEM is ignored
        cyc(0, I_ADD, 1, 0, 0, O_FHIT,  "add_fetch");
        cyc(0, I_ADD, 1, 0, 0, O_ZERO,  "add_decode");
        cyc(0, I_ADD, 1, 0, 0, O_ZERO,  "add_execute");
        cyc(0, I_ADD, 0, 0, 0, O_WB_RD, "add_writeback");

        // BEQ taken / not taken
        cyc(0, I_BEQ, 1, 0, 0, O_FHIT,  "beq_t_fetch");
        cyc(0, I_BEQ, 0, 0, 1, O_ZERO,  "beq_t_decode");
        cyc(0, I_BEQ, 0, 0, 1, O_BR_T,  "beq_t_execute");
        cyc(0, I_BEQ, 1, 0, 0, O_FHIT,  "beq_nt_fetch");
        cyc(0, I_BEQ, 0, 0, 0, O_ZERO,  "beq_nt_decode");
        cyc(0, I_BEQ, 0, 0, 0, O_BR_NT, "beq_nt_execute");

        // LW with three wait cycles in MEM (fourth wait count meets MemReady)
        cyc(0, I_LW, 1, 0, 0, O_FHIT,   "lw_fetch");
        cyc(0, I_LW, 0, 0, 0, O_ZERO,   "lw_decode");
        cyc(0, I_LW, 0, 0, 0, O_ZERO,   "lw_execute");
        for (int i = 0; i < 3; i++)
            cyc(0, I_LW, 0, 0, 0, O_MEM_LD, "lw_mem_wait");
        cyc(0, I_LW, 1, 0, 0, O_MEM_LD, "lw_mem_ready");
        cyc(0, I_LW, 0, 0, 0, O_WB_RD,  "lw_writeback");

        // SW: completes in MEM, no writeback
        cyc(0, I_SW, 1, 0, 0, O_FHIT,   "sw_fetch");
        cyc(0, I_SW, 0, 0, 0, O_ZERO,   "sw_decode");
        cyc(0, I_SW, 0, 0, 0, O_ZERO,   "sw_execute");
        cyc(0, I_SW, 1, 0, 0, O_MEM_ST, "sw_mem");

        // ADDI x0: writeback without register write
        cyc(0, I_NOP, 1, 0, 0, O_FHIT,    "nop_fetch");
        cyc(0, I_NOP, 0, 0, 0, O_ZERO,    "nop_decode");
        cyc(0, I_NOP, 0, 0, 0, O_ZERO,    "nop_execute");
        cyc(0, I_NOP, 0, 0, 0, O_WB_NORD, "nop_writeback");

        // JAL x1 and JALR x0
        cyc(0, I_JAL, 1, 0, 0, O_FHIT,     "jal_fetch");
        cyc(0, I_JAL, 0, 0, 0, O_ZERO,     "jal_decode");
        cyc(0, I_JAL, 0, 0, 0, O_ZERO,     "jal_execute");
        cyc(0, I_JAL, 0, 0, 0, O_WB_JAL,   "jal_writeback");
        cyc(0, I_JALR, 1, 0, 0, O_FHIT,    "jalr_fetch");
        cyc(0, I_JALR, 0, 0, 0, O_ZERO,    "jalr_decode");
        cyc(0, I_JALR, 0, 0, 0, O_ZERO,    "jalr_execute");
        cyc(0, I_JALR, 0, 0, 0, O_WB_JALR0, "jalr_writeback");

        // Illegal instruction (flag during FETCH is ignored, sampled in DECODE)
        cyc(0, I_BAD, 1, 1, 0, O_FHIT,     "illegal_fetch");
        cyc(0, I_BAD, 0, 1, 0, O_ZERO,     "illegal_decode");
        cyc(0, I_BAD, 0, 0, 0, O_TRAP_ILL, "illegal_trap");

        // Bus timeout after exactly four FETCH cycles
        for (int i = 0; i < 4; i++)
            cyc(0, I_ADD, 0, 0, 0, O_FWAIT, "timeout_fetch_wait");
        cyc(0, I_ADD, 0, 0, 0, O_TRAP_TO, "timeout_trap");

        // MemReady on the fourth cycle wins over expiry
        for (int i = 0; i < 3; i++)
            cyc(0, I_ADD, 0, 0, 0, O_FWAIT, "late_fetch_wait");
        cyc(0, I_ADD, 1, 0, 0, O_FHIT,  "late_fetch_ready");
        cyc(0, I_ADD, 0, 0, 0, O_ZERO,  "late_decode");
        cyc(0, I_ADD, 0, 0, 0, O_ZERO,  "late_execute");
        cyc(0, I_ADD, 0, 0, 0, O_WB_RD, "late_writeback");

        // ECALL halts, sticky against memory handshakes
        cyc(0, I_ECALL, 1, 0, 0, O_FHIT, "ecall_fetch");
        cyc(0, I_ECALL, 0, 0, 0, O_ZERO, "ecall_decode");
        for (int i = 0; i < 4; i++)
            cyc(0, I_ADD, (i % 2 == 0), 0, 1, O_HALT, "halted");

        // Reset out of HALT, then reset asserted mid-MEM on a load
        cyc(1, I_LW, 0, 0, 0, O_ZERO, "halt_reset");
        cyc(0, I_LW, 0, 0, 0, O_ZERO, "idle_after_halt");
        cyc(0, I_LW, 1, 0, 0, O_FHIT,   "lw2_fetch");
        cyc(0, I_LW, 0, 0, 0, O_ZERO,   "lw2_decode");
        cyc(0, I_LW, 0, 0, 0, O_ZERO,   "lw2_execute");
        cyc(0, I_LW, 0, 0, 0, O_MEM_LD, "lw2_mem_wait");
        cyc(1, I_LW, 0, 0, 0, O_ZERO,   "reset_mid_mem");
        cyc(1, I_LW, 1, 0, 0, O_ZERO,   "reset_held");
        cyc(0, I_LW, 0, 0, 0, O_ZERO,   "idle_after_reset");
        cyc(0, I_LW, 0, 0, 0, O_FWAIT,  "fetch_after_reset");

        @(negedge Clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
